multi_line_scheduler: RTL and testbench

MULTI_LINE_SCHEDULER -- requirements
Module: multi_line_scheduler

---
 rtl/multi_line_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_multi_line_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_line_scheduler.sv
// Sweeps enabled line-buffer channels in index order: trigger, wait for busy to clear, gap, next.
// The selected channel's data, row and read strobe are muxed onto one downstream port.
module multi_line_scheduler #(
   parameter int CH_NUM  = 2,
   parameter int DATA_W  = 16,
   parameter int ROW_W   = 11,
   parameter int TIMEOUT = 65535,
   parameter int GAP_CYC = 1
) (
   input  logic                     rclk,
   input  logic                     rst,
   input  logic                     trig,
   input  logic                     cont_mode,
   input  logic [CH_NUM-1:0]        ch_en,
   output logic [CH_NUM-1:0]        ch_trig,
   input  logic [CH_NUM-1:0]        ch_busy,
   input  logic [CH_NUM-1:0]        ch_aquire,
   input  logic [CH_NUM-1:0]        ch_err,
   input  logic [CH_NUM*DATA_W-1:0] ch_data,
   input  logic [CH_NUM*ROW_W-1:0]  ch_row,
   output logic [CH_NUM-1:0]        ch_re,
   input  logic                     read_en,
   output logic                     aquire,
   output logic [DATA_W-1:0]        cam_data,
   output logic [ROW_W-1:0]         cam_row,
   output logic [CH_NUM-1:0]        cam_id,
   output logic                     sweep_done,
   output logic                     timeout,
   output logic                     error
);
   localparam int CW   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int WD_W = 20;
   localparam logic [CW-1:0] LAST = CW'(CH_NUM-1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SELECT = 3'd1,
      TRIG   = 3'd2,
      WAIT   = 3'd3,
      GAP    = 3'd4
   } state_t;

   state_t              state, state_n;
   logic [CW-1:0]       cur, cur_n;
   logic                pending, pend_clr;
   logic [WD_W-1:0]     wd, wd_n, wd_inc;
   logic                wd_hit;
   logic [7:0]          gcnt, gcnt_n;
   logic [CH_NUM-1:0]   trig_n;
   logic                done_n, to_set, eos;
   logic [CW-1:0]       sel_idx;
   logic                sel_ok;

   // Lowest enabled channel at or above cur; the descending loop leaves the lowest match.
   always_comb begin
      sel_idx = cur;
      sel_ok  = 1'b0;
      for (int i = CH_NUM-1; i >= 0; i--) begin
         if (ch_en[i] && (CW'(i) >= cur)) begin
            sel_idx = CW'(i);
            sel_ok  = 1'b1;
         end
      end
   end

   assign wd_inc = wd + 1'b1;
   assign wd_hit = (wd_inc == WD_W'(TIMEOUT));

   always_comb begin
      state_n  = state;
      cur_n    = cur;
      pend_clr = 1'b0;
      wd_n     = wd;
      gcnt_n   = (state == GAP) ? gcnt + 8'd1 : 8'd0;
      trig_n   = ch_trig;
      done_n   = 1'b0;
      to_set   = 1'b0;
      eos      = 1'b0;
      case (state)
         IDLE: begin
            cur_n  = '0;
            trig_n = '0;
            if (pending) begin
               state_n  = SELECT;
               pend_clr = 1'b1;
            end
         end
         SELECT: begin
            if (sel_ok) begin
               cur_n   = sel_idx;
               state_n = TRIG;
               wd_n    = '0;
               trig_n  = CH_NUM'(1) << sel_idx;
            end else begin
               eos = 1'b1;
            end
         end
         TRIG: begin
            wd_n = wd_inc;
            if (ch_busy[cur]) begin
               trig_n  = '0;
               state_n = WAIT;
            end else if (wd_hit) begin
               to_set  = 1'b1;
               trig_n  = '0;
               state_n = GAP;
            end
         end
         WAIT: begin
            wd_n = wd_inc;
            if (!ch_busy[cur]) begin
               state_n = GAP;
            end else if (wd_hit) begin
               to_set  = 1'b1;
               state_n = GAP;
            end
         end
         GAP: begin
            trig_n = '0;
            if (gcnt == 8'(GAP_CYC-1)) begin
               if (cur == LAST) begin
                  eos = 1'b1;
               end else begin
                  cur_n   = cur + 1'b1;
                  state_n = SELECT;
               end
            end
         end
         default: begin
            state_n = IDLE;
            cur_n   = '0;
            trig_n  = '0;
         end
      endcase
      // End of sweep: restart immediately when continuous or a sweep is queued.
      if (eos) begin
         done_n = 1'b1;
         cur_n  = '0;
         if (cont_mode || pending) begin
            state_n  = SELECT;
            pend_clr = 1'b1;
         end else begin
            state_n = IDLE;
         end
      end
   end

   always_ff @(posedge rclk) begin
      if (rst) begin
         state      <= IDLE;
         cur        <= '0;
         pending    <= 1'b0;
         wd         <= '0;
         gcnt       <= 8'd0;
         ch_trig    <= '0;
         sweep_done <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state      <= state_n;
         cur        <= cur_n;
         wd         <= wd_n;
         gcnt       <= gcnt_n;
         ch_trig    <= trig_n;
         sweep_done <= done_n;
         if (to_set)
            timeout <= 1'b1;
         // A new request wins over the clear so a trig is never lost.
         if (trig)
            pending <= 1'b1;
         else if (pend_clr)
            pending <= 1'b0;
      end
   end

   always_comb begin
      cam_id   = CH_NUM'(1) << cur;
      ch_re    = read_en ? cam_id : '0;
      aquire   = ch_aquire[cur];
      cam_data = '0;
      cam_row  = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (CW'(i) == cur) begin
            cam_data = ch_data[i*DATA_W +: DATA_W];
            cam_row  = ch_row[i*ROW_W +: ROW_W];
         end
      end
   end

   assign error = (|ch_err) | timeout;

endmodule

// File: tb/tb_multi_line_scheduler.sv
// Scoreboard bench: expected trigger order and sweep_done markers are queued at stimulus time
// and consumed by a monitor as the scheduler produces them.
module tb_multi_line_scheduler;
   localparam int CH  = 4;
   localparam int DW  = 16;
   localparam int RW  = 11;
   localparam int TO  = 20;
   localparam int GAP = 2;
   localparam int SD_TOK = 99;

   logic              rclk = 1'b0;
   logic              rst = 1'b1;
   logic              trig = 1'b0;
   logic              cont_mode = 1'b0;
   logic              read_en = 1'b0;
   logic [CH-1:0]     ch_en = '0;
   logic [CH-1:0]     ch_busy = '0;
   logic [CH-1:0]     ch_aquire = 4'b0101;
   logic [CH-1:0]     ch_err = '0;
   logic [CH*DW-1:0]  ch_data;
   logic [CH*RW-1:0]  ch_row;
   logic [CH-1:0]     ch_trig, ch_re, cam_id;
   logic              aquire, sweep_done, timeout, error;
   logic [DW-1:0]     cam_data;
   logic [RW-1:0]     cam_row;
   logic [CH-1:0]     dead = '0;

   int n_cmp = 0;
   int n_err = 0;
   int exp_q[$];
   int sd_cnt = 0;
   int cur_exp = 0;

   multi_line_scheduler #(
      .CH_NUM(CH), .DATA_W(DW), .ROW_W(RW), .TIMEOUT(TO), .GAP_CYC(GAP)
   ) dut (
      .rclk(rclk), .rst(rst), .trig(trig), .cont_mode(cont_mode), .ch_en(ch_en),
      .ch_trig(ch_trig), .ch_busy(ch_busy), .ch_aquire(ch_aquire), .ch_err(ch_err),
      .ch_data(ch_data), .ch_row(ch_row), .ch_re(ch_re), .read_en(read_en),
      .aquire(aquire), .cam_data(cam_data), .cam_row(cam_row), .cam_id(cam_id),
      .sweep_done(sweep_done), .timeout(timeout), .error(error)
   );

   always #5 rclk = ~rclk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic int idx_of(input logic [CH-1:0] v);
      for (int i = 0; i < CH; i++)
         if (v[i]) return i;
      return -1;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge rclk);
   endtask

   task automatic pulse_trig();
      trig = 1'b1;
      tick(1);
      trig = 1'b0;
   endtask

   task automatic wait_sd(input int budget);
      int c = 0;
      tick(1);
      while (!sweep_done && c < budget) begin
         tick(1);
         c++;
      end
      chk("wait_sweep_done", sweep_done, 1);
   endtask

   task automatic wait_trig(input int budget);
      int c = 0;
      while (ch_trig == '0 && c < budget) begin
         tick(1);
         c++;
      end
      chk("wait_ch_trig", (ch_trig != '0), 1);
   endtask

   initial begin
      for (int i = 0; i < CH; i++) begin
         ch_data[i*DW +: DW] = DW'(16'hA000 + i*16'h0111);
         ch_row[i*RW +: RW]  = RW'(100 + i);
      end
   end

   initial begin : read_drv
      forever begin
         @(posedge rclk);
         #1 read_en = 1'($urandom_range(0, 1));
      end
   end

   // Channel model: busy 3 cycles after its trigger rises, for 10 cycles; dead channels never respond.
   initial begin : chan_model
      int dly[CH];
      int bcnt[CH];
      logic [CH-1:0] pt;
      pt = '0;
      for (int i = 0; i < CH; i++) begin
         dly[i] = 0;
         bcnt[i] = 0;
      end
      forever begin
         @(negedge rclk);
         for (int i = 0; i < CH; i++) begin
            if (ch_trig[i] && !pt[i] && !dead[i]) begin
               dly[i] = 3;
            end else if (dly[i] > 0) begin
               dly[i]--;
               if (dly[i] == 0) begin
                  ch_busy[i] = 1'b1;
                  bcnt[i] = 10;
               end
            end else if (bcnt[i] > 0) begin
               bcnt[i]--;
               if (bcnt[i] == 0) ch_busy[i] = 1'b0;
            end
         end
         pt = ch_trig;
      end
   end

   initial begin : monitor
      logic [CH-1:0] pt, rise;
      int len, e;
      pt = '0;
      len = 0;
      forever begin
         @(negedge rclk);
         if (rst) begin
            pt = '0;
            len = 0;
         end else begin
            rise = ch_trig & ~pt;
            if (rise != '0) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_trig", rise, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("trig_order", idx_of(rise), e);
                  cur_exp = e;
               end
            end
            if (ch_trig != '0) begin
               chk("trig_onehot", $countones(ch_trig), 1);
               chk("cam_id", cam_id, 1 << cur_exp);
               chk("ch_re", ch_re, read_en ? (1 << cur_exp) : 0);
               chk("cam_data", cam_data, ch_data[cur_exp*DW +: DW]);
               chk("cam_row", cam_row, ch_row[cur_exp*RW +: RW]);
               chk("aquire", aquire, ch_aquire[cur_exp]);
            end
            if (dead[0]) begin
               if (ch_trig[0]) len++;
               else if (pt[0]) begin
                  chk("watchdog_len", len, TO);
                  len = 0;
               end
            end
            if (sweep_done) begin
               sd_cnt++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("done_order", e, SD_TOK);
               end
            end
            pt = ch_trig;
         end
      end
   end

   initial begin : guard
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int base;
      tick(3);
      chk("rst_ch_trig", ch_trig, 0);
      chk("rst_sweep_done", sweep_done, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_error", error, 0);
      chk("rst_cam_id", cam_id, 4'b0001);
      chk("rst_ch_re", ch_re, read_en ? 4'b0001 : 4'b0000);
      rst = 1'b0;
      tick(2);

      // Two low channels, one sweep, then idle on channel 0.
      ch_en = 4'b0011;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(SD_TOK);
      pulse_trig();
      wait_sd(200);
      tick(3);
      chk("idle_cam_id", cam_id, 4'b0001);
      chk("sb_empty_a", exp_q.size(), 0);

      // Sparse mask: only channels 1 and 3.
      ch_en = 4'b1010;
      exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(SD_TOK);
      pulse_trig();
      wait_sd(200);
      tick(3);
      chk("sb_empty_b", exp_q.size(), 0);

      // Mask cleared while channel 1 is in service: it still completes.
      exp_q.push_back(1); exp_q.push_back(SD_TOK);
      pulse_trig();
      wait_trig(20);
      tick(6);
      ch_en = 4'b0000;
      wait_sd(200);
      tick(3);
      chk("sb_empty_mask_change", exp_q.size(), 0);

      // Nothing enabled: done exactly two cycles after trig, no triggers.
      exp_q.push_back(SD_TOK);
      trig = 1'b1;
      tick(1);
      trig = 1'b0;
      chk("empty_done_c1", sweep_done, 0);
      tick(1);
      chk("empty_done_c2", sweep_done, 0);
      tick(1);
      chk("empty_done_c3", sweep_done, 1);
      tick(3);
      chk("sb_empty_none", exp_q.size(), 0);

      // Channel 0 never responds: watchdog fires, channel 1 still served.
      chk("pre_timeout", timeout, 0);
      dead = 4'b0001;
      ch_en = 4'b0011;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(SD_TOK);
      pulse_trig();
      wait_sd(300);
      tick(2);
      dead = 4'b0000;
      chk("timeout_set", timeout, 1);
      chk("error_from_timeout", error, 1);
      chk("sb_empty_to", exp_q.size(), 0);

      // Continuous mode: back-to-back sweeps, then stop after the third.
      ch_en = 4'b0001;
      cont_mode = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(0);
         exp_q.push_back(SD_TOK);
      end
      pulse_trig();
      wait_sd(200);
      begin
         int c = 0;
         do begin
            tick(1);
            c++;
         end while (ch_trig == '0 && c < 10);
         chk("b2b_restart_gap", c, 1);
      end
      wait_sd(200);
      cont_mode = 1'b0;
      wait_sd(200);
      tick(40);
      chk("sb_empty_cont", exp_q.size(), 0);
      chk("timeout_sticky", timeout, 1);

      // A trig during a sweep queues exactly one more sweep.
      ch_en = 4'b0011;
      base = sd_cnt;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(SD_TOK);
      end
      pulse_trig();
      wait_trig(20);
      tick(2);
      pulse_trig();
      wait_sd(300);
      wait_sd(300);
      tick(60);
      chk("two_sweeps", sd_cnt - base, 2);
      chk("sb_empty_queue", exp_q.size(), 0);

      // Reset mid-WAIT, with a trig in the reset cycle that must be ignored.
      ch_en = 4'b0001;
      exp_q.push_back(0); exp_q.push_back(SD_TOK);
      pulse_trig();
      wait_trig(20);
      tick(8);
      chk("in_wait_trig_low", ch_trig, 0);
      rst = 1'b1;
      trig = 1'b1;
      exp_q.delete();
      base = sd_cnt;
      tick(1);
      trig = 1'b0;
      chk("mid_rst_ch_trig", ch_trig, 0);
      chk("mid_rst_sweep_done", sweep_done, 0);
      chk("mid_rst_timeout", timeout, 0);
      chk("mid_rst_error", error, 0);
      chk("mid_rst_cam_id", cam_id, 4'b0001);
      rst = 1'b0;
      tick(40);
      chk("no_done_after_rst", sd_cnt - base, 0);

      ch_err = 4'b0100;
      tick(1);
      chk("error_from_ch_err", error, 1);
      ch_err = 4'b0000;
      tick(1);
      chk("error_clear", error, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
